// File: rtl/dte_ebus_arb_if.sv
// dte_ebus_arb_if: EBUS request/grant and watchdog status bundle between requesters and the arbiter.
interface dte_ebus_arb_if #(parameter int NREQ = 4);
  localparam int IW = NREQ > 2 ? $clog2(NREQ) : 1;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic clrErr;
  logic busy;
  logic timeoutErr;
  logic [IW-1:0] timeoutWho;
  modport master(output req, clrErr, input grant, busy, timeoutErr, timeoutWho);
  modport slave(input req, clrErr, output grant, busy, timeoutErr, timeoutWho);
endinterface

// File: rtl/dte_ebus_arb.sv
// dte_ebus_arb: round-robin EBUS arbiter with turnaround gap and per-tenure watchdog lockout.
module dte_ebus_arb #(
  parameter int NREQ = 4,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic CROBAR,
  dte_ebus_arb_if.slave bus
);
  localparam int IW = NREQ > 2 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
  state_t state, state_n;
  logic [IW-1:0] owner, owner_n, ptr, ptr_n, win, who, who_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NREQ-1:0] lock, lock_n, grant, grant_n, elig;
  logic err, err_n, found;
  assign elig = bus.req & ~lock;
  // Descending scan so the lowest offset from ptr is the final assignment.
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[(int'(ptr) + k) % NREQ]) begin
        win = IW'((int'(ptr) + k) % NREQ);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n = ptr;
    cnt_n = cnt;
    grant_n = grant;
    lock_n = lock & bus.req;
    err_n = err & ~bus.clrErr;
    who_n = who;
    if (state == IDLE && found) begin
      state_n = OWN;
      owner_n = win;
      ptr_n = win == IW'(NREQ - 1) ? '0 : win + 1'b1;
      cnt_n = '0;
      grant_n = NREQ'(1) << win;
    end else if (state == OWN) begin
      if (!bus.req[owner]) begin
        state_n = GAP;
        grant_n = '0;
      end else if (cnt == CW'(TIMEOUT)) begin
        state_n = GAP;
        grant_n = '0;
        lock_n[owner] = 1'b1;
        err_n = 1'b1;
        who_n = owner;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end else if (state == GAP) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state <= IDLE;
      owner <= '0;
      ptr <= '0;
      cnt <= '0;
      grant <= '0;
      lock <= '0;
      err <= 1'b0;
      who <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      grant <= grant_n;
      lock <= lock_n;
      err <= err_n;
      who <= who_n;
    end
  end
  assign bus.grant = grant;
  assign bus.busy = |grant;
  assign bus.timeoutErr = err;
  assign bus.timeoutWho = who;
endmodule
